mic_sequencer: RTL and testbench

//  Microsequencer for the MIC control store. Generates MPC for the 512x39 microprogram
//  ROM from the decoded NEXT_ADDRESS/JAM/MEM fields, ALU N/Z and MBR.

---
 rtl/mic_pkg.sv | 28 ++
 rtl/mic_nextaddr.sv | 21 ++
 rtl/mic_sequencer.sv | 113 +++++++++++
 tb/tb_mic_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mic_pkg.sv
// Shared types and field encodings for the MIC microsequencer.
package mic_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        WAIT = 2'b10,
        HALT = 2'b11
    } seq_state_t;

    // Bit positions inside the decoded JAM and MEM microinstruction fields.
    localparam int JAM_JMPC  = 2;
    localparam int JAM_JAMN  = 1;
    localparam int JAM_JAMZ  = 0;
    localparam int MEM_WRITE = 2;
    localparam int MEM_READ  = 1;
    localparam int MEM_FETCH = 0;

    localparam logic [8:0]  DEF_RESET_ADDR = 9'h000;
    localparam logic [8:0]  DEF_HALT_ADDR  = 9'h1FF;
    localparam int unsigned DEF_MEM_LAT    = 2;
    localparam int          CNT_W          = 4;

    function automatic logic mem_request(input logic [2:0] mem);
        return mem[MEM_WRITE] | mem[MEM_READ] | mem[MEM_FETCH];
    endfunction

endpackage

// File: rtl/mic_nextaddr.sv
// Combinational next-MPC: JMPC ORs MBR into the low byte, JAMN/JAMZ OR the flags into bit 8.
module mic_nextaddr
    import mic_pkg::*;
(
    input  logic [8:0] next_addr,
    input  logic [2:0] jam,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic [7:0] mbr,
    output logic [8:0] nmpc
);

    logic [7:0] low8;
    logic       hi;

    // Pure OR composition: no carry out of the low byte, no wrap.
    assign low8 = jam[JAM_JMPC] ? (next_addr[7:0] | mbr) : next_addr[7:0];
    assign hi   = next_addr[8] | (jam[JAM_JAMN] & alu_n) | (jam[JAM_JAMZ] & alu_z);
    assign nmpc = {hi, low8};

endmodule

// File: rtl/mic_sequencer.sv
// MIC microsequencer: drives the control-store MPC and READ, stalls for memory and pauses.
module mic_sequencer
    import mic_pkg::*;
#(
    parameter logic [8:0]  RESET_ADDR = DEF_RESET_ADDR,
    parameter logic [8:0]  HALT_ADDR  = DEF_HALT_ADDR,
    parameter int unsigned MEM_LAT    = DEF_MEM_LAT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] next_addr,
    input  logic [2:0] jam,
    input  logic [2:0] mem,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic [7:0] mbr,
    input  logic       halt_req,
    output logic [8:0] mpc,
    output logic       rom_read,
    output logic       stall,
    output logic       n_flag,
    output logic       z_flag,
    output logic [1:0] state
);

    seq_state_t       state_q, state_d;
    logic [8:0]       mpc_q, mpc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             n_q, n_d;
    logic             z_q, z_d;
    logic             parked_q, parked_d;   // HALT entered via HALT_ADDR: only reset leaves
    logic [8:0]       nmpc;

    mic_nextaddr u_nextaddr (
        .next_addr (next_addr),
        .jam       (jam),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .mbr       (mbr),
        .nmpc      (nmpc)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d  = state_q;
        mpc_d    = mpc_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        z_d      = z_q;
        parked_d = parked_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (nmpc == HALT_ADDR) begin
                    mpc_d    = nmpc;
                    state_d  = HALT;
                    parked_d = 1'b1;
                    n_d      = alu_n;
                    z_d      = alu_z;
                end else if (mem_request(mem)) begin
                    mpc_d   = nmpc;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = WAIT;
                    n_d     = alu_n;
                    z_d     = alu_z;
                end else if (halt_req) begin
                    state_d = HALT;
                end else begin
                    mpc_d = nmpc;
                    n_d   = alu_n;
                    z_d   = alu_z;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = halt_req ? HALT : RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HALT: begin
                // Resuming goes through BOOT so the ROM output is re-primed before RUN.
                if (!parked_q && !halt_req) state_d = BOOT;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            mpc_q    <= RESET_ADDR;
            cnt_q    <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            parked_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_d;
            mpc_q    <= mpc_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            z_q      <= z_d;
            parked_q <= parked_d;
        end
    end

    // READ is forced low while reset is asserted even though BOOT is already loaded.
    assign rom_read = reset & ((state_q == BOOT) || (state_q == RUN));
    assign stall    = (state_q != RUN);
    assign mpc      = mpc_q;
    assign n_flag   = n_q;
    assign z_flag   = z_q;
    assign state    = state_q;

endmodule

// File: tb/tb_mic_sequencer.sv
// Directed bench for mic_sequencer (MEM_LAT=3): sequencing, dispatch, memory stall, halt paths.
module tb_mic_sequencer;
    import mic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] next_addr;
    logic [2:0] jam;
    logic [2:0] mem;
    logic       alu_n;
    logic       alu_z;
    logic [7:0] mbr;
    logic       halt_req;
    logic [8:0] mpc;
    logic       rom_read;
    logic       stall;
    logic       n_flag;
    logic       z_flag;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    mic_sequencer #(
        .RESET_ADDR (9'h000),
        .HALT_ADDR  (9'h1FF),
        .MEM_LAT    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .next_addr (next_addr),
        .jam       (jam),
        .mem       (mem),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .mbr       (mbr),
        .halt_req  (halt_req),
        .mpc       (mpc),
        .rom_read  (rom_read),
        .stall     (stall),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Checks state, rom_read, stall and mpc together.
    task automatic check_status(input string tag, input seq_state_t exp_st, input logic exp_rd,
                                input logic exp_stall, input logic [8:0] exp_mpc);
        check({tag, ".state"}, 9'(state), 9'(exp_st));
        check({tag, ".rom_read"}, 9'(rom_read), 9'(exp_rd));
        check({tag, ".stall"}, 9'(stall), 9'(exp_stall));
        check({tag, ".mpc"}, mpc, exp_mpc);
    endtask

    task automatic check_flags(input string tag, input logic exp_n, input logic exp_z);
        check({tag, ".n_flag"}, 9'(n_flag), 9'(exp_n));
        check({tag, ".z_flag"}, 9'(z_flag), 9'(exp_z));
    endtask

    task automatic drive(input logic [8:0] na, input logic [2:0] j, input logic [2:0] m,
                         input logic n, input logic z, input logic [7:0] b, input logic h);
        next_addr = na;
        jam       = j;
        mem       = m;
        alu_n     = n;
        alu_z     = z;
        mbr       = b;
        halt_req  = h;
    endtask

    initial begin
        reset = 1'b0;
        drive(9'h000, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);

        // Reset state and release.
        repeat (2) tick();
        check_status("reset", BOOT, 1'b0, 1'b1, 9'h000);
        check_flags("reset", 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_status("boot", BOOT, 1'b1, 1'b1, 9'h000);
        tick();
        check_status("boot_to_run", RUN, 1'b1, 1'b0, 9'h000);

        // Plain sequencing and branch/dispatch.
        drive(9'h012, 3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check_status("plain", RUN, 1'b1, 1'b0, 9'h012);
        check_flags("plain", 1'b1, 1'b0);
        drive(9'h100, 3'b100, 3'b000, 1'b0, 1'b0, 8'h59, 1'b0);
        tick();
        check("jmpc.mpc", mpc, 9'h159);
        check_flags("jmpc", 1'b0, 1'b0);
        drive(9'h020, 3'b001, 3'b000, 1'b0, 1'b1, 8'hFF, 1'b0);
        tick();
        check("jamz_taken.mpc", mpc, 9'h120);
        check_flags("jamz_taken", 1'b0, 1'b1);
        drive(9'h020, 3'b010, 3'b000, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        check("jamn_not_taken.mpc", mpc, 9'h020);
        drive(9'h020, 3'b010, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check("jamn_taken.mpc", mpc, 9'h120);
        check_flags("jamn_taken", 1'b1, 1'b0);

        // Memory stall: three WAIT cycles with MEM_LAT=3, flags frozen.
        drive(9'h030, 3'b000, 3'b010, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        check_status("mem_w0", WAIT, 1'b0, 1'b1, 9'h030);
        check_flags("mem_w0", 1'b0, 1'b1);
        drive(9'h055, 3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check_status("mem_w1", WAIT, 1'b0, 1'b1, 9'h030);
        tick();
        check_status("mem_w2", WAIT, 1'b0, 1'b1, 9'h030);
        check_flags("mem_w2", 1'b0, 1'b1);
        tick();
        check_status("mem_done", RUN, 1'b1, 1'b0, 9'h030);
        tick();
        check("mem_next.mpc", mpc, 9'h055);
        check_flags("mem_next", 1'b1, 1'b0);

        // halt_req together with a memory request: WAIT completes first, then HALT.
        drive(9'h066, 3'b000, 3'b001, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check_status("memhalt_w0", WAIT, 1'b0, 1'b1, 9'h066);
        drive(9'h077, 3'b000, 3'b000, 1'b1, 1'b1, 8'h00, 1'b1);
        tick();
        check_status("memhalt_w1", WAIT, 1'b0, 1'b1, 9'h066);
        tick();
        check_status("memhalt_w2", WAIT, 1'b0, 1'b1, 9'h066);
        tick();
        check_status("memhalt_halt", HALT, 1'b0, 1'b1, 9'h066);
        tick();
        check_status("memhalt_hold", HALT, 1'b0, 1'b1, 9'h066);
        check_flags("memhalt_hold", 1'b0, 1'b0);
        halt_req = 1'b0;
        tick();
        check_status("resume_boot", BOOT, 1'b1, 1'b1, 9'h066);
        tick();
        check_status("resume_run", RUN, 1'b1, 1'b0, 9'h066);
        tick();
        check("resume_next.mpc", mpc, 9'h077);
        check_flags("resume_next", 1'b1, 1'b1);

        // halt_req alone in RUN: mpc and flags held.
        drive(9'h088, 3'b000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        check_status("pause", HALT, 1'b0, 1'b1, 9'h077);
        check_flags("pause", 1'b1, 1'b1);
        halt_req = 1'b0;
        tick();
        check_status("pause_boot", BOOT, 1'b1, 1'b1, 9'h077);
        tick();
        check_status("pause_run", RUN, 1'b1, 1'b0, 9'h077);
        tick();
        check("pause_next.mpc", mpc, 9'h088);
        check_flags("pause_next", 1'b0, 1'b0);

        // HALT_ADDR parks the sequencer; halt_req activity must not release it.
        drive(9'h1FF, 3'b000, 3'b000, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        check_status("park", HALT, 1'b0, 1'b1, 9'h1FF);
        check_flags("park", 1'b0, 1'b1);
        drive(9'h012, 3'b000, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            halt_req = ((i % 4) == 1);
            tick();
            check_status($sformatf("park_hold%0d", i), HALT, 1'b0, 1'b1, 9'h1FF);
        end
        check_flags("park_hold", 1'b0, 1'b1);

        // Asynchronous reset mid-HALT.
        halt_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_status("reset_halt", BOOT, 1'b0, 1'b1, 9'h000);
        check_flags("reset_halt", 1'b0, 1'b0);
        #2 reset = 1'b1;
        tick();
        check_status("reset_halt_run", RUN, 1'b1, 1'b0, 9'h000);
        tick();
        check("reset_halt_next.mpc", mpc, 9'h012);

        // Asynchronous reset mid-WAIT.
        drive(9'h040, 3'b000, 3'b010, 1'b1, 1'b1, 8'h00, 1'b0);
        tick();
        check_status("wait_enter", WAIT, 1'b0, 1'b1, 9'h040);
        mem = 3'b000;
        #2 reset = 1'b0;
        #1;
        check_status("reset_wait", BOOT, 1'b0, 1'b1, 9'h000);
        check_flags("reset_wait", 1'b0, 1'b0);
        #2 reset = 1'b1;
        tick();
        check_status("reset_wait_run", RUN, 1'b1, 1'b0, 9'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
